// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Streaming-to-frame input stage for fft16_iterative. Samples arrive one per
// cycle on a valid/ready handshake and are assembled into N-sample frames in
// a ping-pong pair of banks. A completed frame is presented in parallel to
// the FFT with its mode bit, launched with a one-cycle start pulse, and held
// stable until the FFT reports done. The other bank fills meanwhile.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     sample handshake
//   s_real/s_imag       signed sample, DATA_W bits each
//   s_mode              0 = FFT, 1 = IFFT; taken from the first sample of a frame
//   frame_real/imag     presented frame (natural order), to the FFT data inputs
//   fft_mode            mode of the presented frame
//   fft_start           one-cycle launch pulse
//   fft_done            FFT completion, level or pulse (rising edge used)
//   busy                a frame is launched and awaiting fft_done
module fft_frame_loader #(
    parameter int N      = 16,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_real,
    input  logic signed [DATA_W-1:0] s_imag,
    input  logic                     s_mode,
    output logic signed [DATA_W-1:0] frame_real [0:N-1],
    output logic signed [DATA_W-1:0] frame_imag [0:N-1],
    output logic                     fft_mode,
    output logic                     fft_start,
    input  logic                     fft_done,
    output logic                     busy
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] bank_re [0:1][0:N-1];
    logic signed [DATA_W-1:0] bank_im [0:1][0:N-1];
    logic [1:0]       bank_mode;
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             done_q;
    logic             wr_fire;
    logic             wr_last;
    logic             release_bank;

    // Purely registered: no combinational path from s_valid to s_ready.
    assign s_ready = !full[wr_bank];
    assign wr_fire = s_valid && s_ready;
    assign wr_last = (wr_idx == IDX_W'(N - 1));

    // Write side: sample storage, per-bank mode and fill pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    bank_re[b][i] <= '0;
                    bank_im[b][i] <= '0;
                end
            end
            bank_mode <= '0;
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
        end else if (wr_fire) begin
            bank_re[wr_bank][wr_idx] <= s_real;
            bank_im[wr_bank][wr_idx] <= s_imag;
            if (wr_idx == '0)
                bank_mode[wr_bank] <= s_mode;
            if (wr_last) begin
                wr_idx  <= '0;
                wr_bank <= !wr_bank;
            end else begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

    // Full flags: the write side sets, the read side clears. They can act in
    // the same cycle only on different banks, so per-bank priority is moot.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_fire && wr_last && (wr_bank == 1'(b)))
                    full[b] <= 1'b1;
                else if (release_bank && (rd_bank == 1'(b)))
                    full[b] <= 1'b0;
            end
        end
    end

    // Read side: launch FSM state, presented bank and done edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= fft_done;
            if (release_bank)
                rd_bank <= !rd_bank;
        end
    end

    // Release needs a fresh rising edge of done, so a done level left high
    // from the previous frame cannot release the one just launched.
    always_comb begin
        state_nxt    = state;
        fft_start    = 1'b0;
        release_bank = 1'b0;
        case (state)
            IDLE:    if (full[rd_bank]) state_nxt = LAUNCH;
            LAUNCH: begin
                fft_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (fft_done && !done_q) begin
                    release_bank = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign fft_mode = bank_mode[rd_bank];

    for (genvar i = 0; i < N; i++) begin : g_out
        assign frame_real[i] = bank_re[rd_bank][i];
        assign frame_imag[i] = bank_im[rd_bank][i];
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Testbench for fft_frame_loader: directed sequence with randomized sample
// values and gaps, checked against a queue of expected frames built from the
// samples as they are sent.
module tb_fft_frame_loader;
    localparam int N = 16;
    localparam int W = 12;

    typedef struct packed {
        logic                md;
        logic [N-1:0][W-1:0] re;
        logic [N-1:0][W-1:0] im;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic s_mode = 1'b0;
    logic fft_done = 1'b0;
    logic signed [W-1:0] s_real = '0;
    logic signed [W-1:0] s_imag = '0;
    logic s_ready, fft_mode, fft_start, busy;
    logic signed [W-1:0] frame_real [0:N-1];
    logic signed [W-1:0] frame_imag [0:N-1];

    int total = 0;
    int passed = 0;
    int starts = 0;
    int launches = 0;
    int s0;
    frame_t exp_q[$];
    frame_t cur;
    int cur_n = 0;

    fft_frame_loader #(.N(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_mode(s_mode),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .fft_mode(fft_mode), .fft_start(fft_start), .fft_done(fft_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fft_start === 1'b1) starts <= starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_frame(input string tag, input bit pop);
        frame_t obs, exp;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed frame with no expected frame queued", tag);
            return;
        end
        exp = exp_q[0];
        if (pop) void'(exp_q.pop_front());
        obs.md = fft_mode;
        for (int i = 0; i < N; i++) begin
            obs.re[i] = frame_real[i];
            obs.im[i] = frame_imag[i];
        end
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One sample through the handshake; the model groups samples into frames.
    task automatic push(input int re, input int im, input logic md);
        int g = 0;
        s_valid = 1'b1;
        s_real  = W'(re);
        s_imag  = W'(im);
        s_mode  = md;
        while (s_ready !== 1'b1 && g < 200) begin
            tick();
            g++;
        end
        if (g == 200) check("push_timeout", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        if (cur_n == 0) cur.md = md;
        cur.re[cur_n] = W'(re);
        cur.im[cur_n] = W'(im);
        cur_n++;
        if (cur_n == N) begin
            exp_q.push_back(cur);
            cur_n = 0;
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic wait_start(input string tag);
        int g = 0;
        while (fft_start !== 1'b1 && g < 40) begin
            tick();
            g++;
        end
        check({tag, "_start"}, 32'(fft_start), 1);
        launches++;
        tick();
        check({tag, "_single"}, 32'(fft_start), 0);
    endtask

    task automatic release_frame();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_start", 32'(fft_start), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(s_ready), 1);
        check("rst_mode", 32'(fft_mode), 0);
        check("rst_fr0", 32'(frame_real[0]), 0);
        check("rst_fi15", 32'(frame_imag[N-1]), 0);

        // Ramp frame, gap-free; exact launch timing
        for (int i = 0; i < N; i++) push(i, 0, 1'b0);
        check("t1_nostart_k", 32'(fft_start), 0);
        check_frame("t1_frame_k", 0);
        tick();
        check("t1_start_k1", 32'(fft_start), 1);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_start_k2", 32'(fft_start), 0);
        launches++;
        repeat (5) tick();
        check("t1_busy_hold", 32'(busy), 1);
        check_frame("t1_frame_hold", 1);
        release_frame();
        check("t1_busy_rel", 32'(busy), 0);

        // Two frames back-to-back with done withheld
        for (int i = 0; i < N; i++) push(100 + i, -i, 1'b1);
        for (int i = 0; i < N; i++) push(-2048 + i, i, 1'b0);
        check("t2_ready_low", 32'(s_ready), 0);
        check("t2_busy", 32'(busy), 1);
        check_frame("t2_A_present", 0);
        repeat (4) tick();
        check("t2_ready_still_low", 32'(s_ready), 0);
        check_frame("t2_A_hold", 1);
        launches++;
        release_frame();
        check("t2_ready_back", 32'(s_ready), 1);
        check("t2_busy_rel", 32'(busy), 0);
        check("t2_nostart_r", 32'(fft_start), 0);
        check_frame("t2_B_present", 0);
        tick();
        check("t2_start_r1", 32'(fft_start), 1);
        tick();
        check("t2_start_r2", 32'(fft_start), 0);
        launches++;
        check_frame("t2_B_hold", 1);
        release_frame();

        // fft_done held high across two launches
        for (int i = 0; i < N; i++) push(rnd(), rnd(), 1'b0);
        wait_start("t3_C");
        check_frame("t3_C", 1);
        fft_done = 1'b1;
        tick();
        check("t3_C_rel", 32'(busy), 0);
        for (int i = 0; i < N; i++) push(rnd(), rnd(), 1'b1);
        wait_start("t3_D");
        repeat (4) tick();
        check("t3_no_double", 32'(busy), 1);
        check_frame("t3_D", 1);
        fft_done = 1'b0;
        tick();
        check("t3_D_wait", 32'(busy), 1);
        fft_done = 1'b1;
        tick();
        check("t3_D_rel", 32'(busy), 0);
        fft_done = 1'b0;

        // Mode only taken from the first sample
        push(rnd(), rnd(), 1'b1);
        for (int i = 1; i < N; i++) push(rnd(), rnd(), 1'b0);
        wait_start("t4");
        check("t4_mode", 32'(fft_mode), 1);
        check_frame("t4_frame", 1);
        release_frame();

        // Random gaps over three frames
        tick();
        s0 = starts;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                push(rnd(), rnd(), 1'($urandom_range(0, 1)));
            end
            wait_start("t5");
            check_frame("t5_frame", 1);
            release_frame();
        end
        tick();
        check("t5_starts", 32'(starts - s0), 3);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 7; i++) push(rnd(), rnd(), 1'b1);
        s0 = starts;
        rst = 1'b1;
        tick();
        check("t6_rst_start", 32'(fft_start), 0);
        check("t6_rst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        cur_n = 0;
        repeat (3) tick();
        check("t6_post_start", 32'(starts - s0), 0);
        check("t6_ready", 32'(s_ready), 1);
        check("t6_cleared", 32'(frame_real[3]), 0);
        for (int i = 0; i < N; i++) push(rnd(), rnd(), 1'b0);
        wait_start("t6");
        check_frame("t6_frame", 1);
        release_frame();

        tick();
        check("start_total", 32'(starts), 32'(launches));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Streaming-to-frame input stage for `fft16_iterative`. Accepts complex samples one per cycle over a valid/ready handshake and assembles them into N-sample frames in a ping-pong pair of banks. Presents each completed frame as parallel unpacked arrays plus a per-frame mode bit, issues `start`, and holds the frame stable until the FFT reports `done`. Filling of the next frame overlaps the current transform.

## Interface

- `N`, 16: samples per frame (power of two).
- `DATA_W`, 12: signed sample width, real and imaginary.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  loader can accept a sample.
- `s_real`  in  DATA_W  signed real part.
- `s_imag`  in  DATA_W  signed imaginary part.
- `s_mode`  in  1  0 = FFT, 1 = IFFT; sampled with the first sample of each frame only.
- `frame_real[0:N-1]`  out  DATA_W each  signed, to FFT `data_real_in`.
- `frame_imag[0:N-1]`  out  DATA_W each  signed, to FFT `data_imag_in`.
- `fft_mode`  out  1  mode of the presented frame, to FFT `mode`.
- `fft_start`  out  1  one-cycle launch pulse, to FFT `start`.
- `fft_done`  in  1  from FFT `done`; level or pulse.
- `busy`  out  1  a frame is launched and awaiting `fft_done`.

## Operation

- Two banks, each with N real words, N imaginary words, a mode bit and a `full` flag. Write-side state: `wr_bank`, `wr_idx` (0..N-1). Read-side state: `rd_bank`.
- `s_ready = !full[wr_bank]`, decoded from registers with no combinational path from inputs.
- On a handshake (`s_valid && s_ready`), write the sample to `bank[wr_bank][wr_idx]`. If `wr_idx == 0`, also capture `s_mode` into that bank's mode bit. If `wr_idx == N-1`, set `full[wr_bank]`, toggle `wr_bank` and clear `wr_idx`; otherwise increment `wr_idx`.
- Samples are stored in natural order, index 0 first. No bit reversal and no sign or width change.
- `frame_real`, `frame_imag` and `fft_mode` are always driven from `rd_bank`.
- Launch FSM, states IDLE, LAUNCH, WAIT:
  - IDLE → LAUNCH when `full[rd_bank]`.
  - LAUNCH → WAIT unconditionally. `fft_start = (state == LAUNCH)`.
  - WAIT → IDLE on a rising edge of `fft_done` (`fft_done && !done_q`). On that transition, clear `full[rd_bank]` and toggle `rd_bank`.
  - `busy = (state != IDLE)`.
- `done_q` is a registered copy of `fft_done`, so a `done` still held high from the previous frame cannot release the current one.
- In the same cycle, a set of `full` on one bank and a clear of `full` on the other are both applied. The same bank is never set and cleared in one cycle.
- Reset mid-frame or mid-transform: the partial frame is discarded, the FSM returns to IDLE and no `fft_start` is issued.

## Timing

- Reset values: `s_ready`=1 (from the first cycle after the reset edge), `fft_start`=0, `busy`=0, `fft_mode`=0, all `frame_*` words 0 (banks cleared). `wr_bank`, `rd_bank`, `wr_idx` and both `full` flags are 0. FSM is in IDLE.
- Throughput: 1 sample/cycle while `s_ready` is high.
- Last sample accepted at edge k. The frame is stable on `frame_*` from edge k. `fft_start` is high for the single cycle between edges k+1 and k+2, so the FFT samples it at edge k+2.
- Frame outputs stay constant from edge k until the edge that releases the bank.
- Back-to-back: if the other bank is already full at release (edge r), the next `fft_start` is high between edges r+1 and r+2.
- With both banks full, `s_ready`=0 until the edge that releases `rd_bank`. `s_ready` is 1 in the following cycle.

## Test plan

- Reset then stream 0..15 real, 0 imag, `s_mode`=0, gap-free → `frame_real[i]=i`. `fft_start` is a single pulse 2 edges after the 16th handshake. `busy`=1 until `fft_done`.
- Stream two frames back-to-back: frame A with `s_mode`=1, frame B with `s_mode`=0 and values -2048..-2033, while `fft_done` is withheld → `s_ready` drops after sample 32. Frame A is held unchanged. Pulse `fft_done` → B presented with `fft_mode`=0, `fft_start` 2 edges later, `s_ready` returns high.
- Hold `fft_done` high continuously across two launches → each frame is released only on a fresh rising edge. No double release.
- Change `s_mode` mid-frame (high on sample 0, low afterwards) → `fft_mode`=1 for that frame.
- Random `s_valid` gaps on 3 frames, checked against a model → every frame matches, 3 `fft_start` pulses, no lost or duplicated sample.
- Assert `rst` after 7 samples, then send 16 new samples → the first launched frame contains only the new 16. No start pulse during or immediately after reset.
